// File: rtl/arki_enc_pkg.sv
// Shared types and opcode constants for the LEGv8 instruction encoder.
// Optional range checking is enabled by defining ARKI_ENC_RANGE_CHECK_EN.
package arki_enc_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_ORR  = 4'd3,
    OP_ADDI = 4'd4,
    OP_LDUR = 4'd5,
    OP_STUR = 4'd6,
    OP_CBZ  = 4'd7,
    OP_CBNZ = 4'd8
  } enc_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE,
    ST_FULL
  } state_t;

  localparam logic [10:0] OPC_ADD  = 11'b100_0101_1000;
  localparam logic [10:0] OPC_SUB  = 11'b110_0101_1000;
  localparam logic [10:0] OPC_AND  = 11'b100_0101_0000;
  localparam logic [10:0] OPC_ORR  = 11'b101_0101_0000;
  localparam logic [9:0]  OPC_ADDI = 10'b10_0100_0100;
  localparam logic [10:0] OPC_LDUR = 11'b111_1100_0010;
  localparam logic [10:0] OPC_STUR = 11'b111_1100_0000;
  localparam logic [7:0]  OPC_CBZ  = 8'b1011_0100;
  localparam logic [7:0]  OPC_CBNZ = 8'b1011_0101;

endpackage

// File: rtl/instr_pack.sv
// Combinational descriptor -> 32-bit LEGv8 word, with optional range_err
// (checks active only when ARKI_ENC_RANGE_CHECK_EN is defined).
module instr_pack
  import arki_enc_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rn,
  input  logic [4:0]  rm,
  input  logic [18:0] imm,
  output logic [31:0] word,
  output logic        range_err
);

  logic [31:0] raw;

  always_comb begin
    raw = 32'h0;
    case (op)
      OP_ADD:  raw = {OPC_ADD, rm, 6'b0, rn, rd};
      OP_SUB:  raw = {OPC_SUB, rm, 6'b0, rn, rd};
      OP_AND:  raw = {OPC_AND, rm, 6'b0, rn, rd};
      OP_ORR:  raw = {OPC_ORR, rm, 6'b0, rn, rd};
      OP_ADDI: raw = {OPC_ADDI, imm[11:0], rn, rd};
      OP_LDUR: raw = {OPC_LDUR, imm[8:0], 2'b00, rn, rd};
      OP_STUR: raw = {OPC_STUR, imm[8:0], 2'b00, rn, rd};
      OP_CBZ:  raw = {OPC_CBZ, imm, rd};
      OP_CBNZ: raw = {OPC_CBNZ, imm, rd};
      default: raw = 32'h0;
    endcase
  end

`ifdef ARKI_ENC_RANGE_CHECK_EN
  logic d_oob;
  logic bad;

  always_comb begin
    // imm[18:8] must be a pure sign extension of the 9-bit DT offset
    d_oob = ~((&imm[18:8]) | ~(|imm[18:8]));
    bad   = 1'b0;
    case (op)
      OP_ADDI:                          bad = |imm[18:12];
      OP_LDUR, OP_STUR:                 bad = d_oob;
      OP_ADD, OP_SUB, OP_AND, OP_ORR,
      OP_CBZ, OP_CBNZ:                  bad = 1'b0;
      default:                          bad = 1'b1;
    endcase
  end

  assign range_err = bad;
  assign word      = bad ? 32'h0 : raw;
`else
  assign range_err = 1'b0;
  assign word      = raw;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Encodes descriptors into LEGv8 words and writes them sequentially to imem, 1-cycle latency.
// Range/opcode error checking is enabled by defining ARKI_ENC_RANGE_CHECK_EN.
module instr_encoder
  import arki_enc_pkg::*;
#(
  parameter  int DEPTH  = 64,
  parameter  int BASE   = 0,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rn,
  input  logic [4:0]        in_rm,
  input  logic [18:0]       in_imm,
  input  logic              in_last,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              done,
  output logic              overflow,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [31:0]         wr_data_q, wr_data_d;
  logic                done_q, done_d;
  logic                overflow_q, overflow_d;
  logic                err_q, err_d;

  logic                accept;
  logic [31:0]         word;
  logic                range_err;

  instr_pack u_pack (
    .op        (in_op),
    .rd        (in_rd),
    .rn        (in_rn),
    .rm        (in_rm),
    .imm       (in_imm),
    .word      (word),
    .range_err (range_err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // in_last wins over the full condition when both land on the final slot
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: begin
        if (start)                             state_d = ST_LOAD;
        else if (accept && in_last)            state_d = ST_DONE;
        else if (accept && (addr_q == LAST_A)) state_d = ST_FULL;
      end
      ST_DONE: if (start) state_d = ST_LOAD;
      ST_FULL: if (start) state_d = ST_LOAD;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == ST_LOAD);
  end

  assign accept = in_valid & in_ready;

  always_comb begin
    addr_d     = addr_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = done_q;
    overflow_d = overflow_q;
    err_d      = err_q;
    if (start) begin
      // a descriptor accepted alongside start is discarded
      addr_d     = BASE_A;
      done_d     = 1'b0;
      overflow_d = 1'b0;
      err_d      = 1'b0;
    end else begin
      if (accept) begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_q;
        wr_data_d = word;
        addr_d    = addr_q + ADDR_W'(1);
        err_d     = err_q | range_err;
        if (in_last) done_d = 1'b1;
      end
      if ((state_q == ST_FULL) && in_valid) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q     <= BASE_A;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= BASE_A;
      wr_data_q  <= 32'h0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      err_q      <= err_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign err      = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder (DEPTH=4) with a write scoreboard;
// expectations follow ARKI_ENC_RANGE_CHECK_EN when it is defined.
module tb_instr_encoder;
  import arki_enc_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_op = 4'd0;
  logic [4:0]    in_rd = 5'd0;
  logic [4:0]    in_rn = 5'd0;
  logic [4:0]    in_rm = 5'd0;
  logic [18:0]   in_imm = 19'd0;
  logic          in_last = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          done;
  logic          overflow;
  logic          err;

  instr_encoder #(.DEPTH(DEPTH), .BASE(0)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_rd    (in_rd),
    .in_rn    (in_rn),
    .in_rm    (in_rm),
    .in_imm   (in_imm),
    .in_last  (in_last),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .done     (done),
    .overflow (overflow),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } exp_t;

  exp_t sb[$];
  int   wr_cyc[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Independent reference encoder built from arithmetic field placement
  function automatic logic [31:0] model(input int op, input int rd, input int rn,
                                        input int rm, input int imm);
    int r;
    case (op)
      0: r = (32'h458 << 21) | (rm << 16) | (rn << 5) | rd;
      1: r = (32'h658 << 21) | (rm << 16) | (rn << 5) | rd;
      2: r = (32'h450 << 21) | (rm << 16) | (rn << 5) | rd;
      3: r = (32'h550 << 21) | (rm << 16) | (rn << 5) | rd;
      4: r = (32'h244 << 22) | ((imm & 32'hFFF) << 10) | (rn << 5) | rd;
      5: r = (32'h7C2 << 21) | ((imm & 32'h1FF) << 12) | (rn << 5) | rd;
      6: r = (32'h7C0 << 21) | ((imm & 32'h1FF) << 12) | (rn << 5) | rd;
      7: r = (32'hB4 << 24) | ((imm & 32'h7FFFF) << 5) | rd;
      8: r = (32'hB5 << 24) | ((imm & 32'h7FFFF) << 5) | rd;
      default: r = 0;
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wr_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        chk("spurious_wr_en", {31'b0, wr_en}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_addr", {30'b0, wr_addr}, {30'b0, e.addr});
        chk("wr_data", wr_data, e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("in_ready_after_start", {31'b0, in_ready}, 32'd1);
  endtask

  task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                      input logic [4:0] rm, input logic [18:0] imm, input logic last,
                      input logic acc, input logic [AW-1:0] addr, input logic [31:0] data);
    exp_t e;
    in_op = op; in_rd = rd; in_rn = rn; in_rm = rm; in_imm = imm; in_last = last;
    in_valid = 1'b1;
    if (acc) begin
      e.addr = addr;
      e.data = data;
      sb.push_back(e);
    end
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_w;
    logic        exp_e;

    // Reset state
    step();
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_wr_en", {31'b0, wr_en}, 32'd0);
    chk("rst_wr_addr", {30'b0, wr_addr}, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_flags", {29'b0, done, overflow, err}, 32'd0);
    reset = 1'b0;
    step();

    // 1: single ADD with last
    start_pulse();
    send(OP_ADD, 5'd3, 5'd1, 5'd2, 19'd0, 1'b1, 1'b1, 2'd0, 32'h8B020023);
    chk("t1_done", {31'b0, done}, 32'd1);
    chk("t1_in_ready", {31'b0, in_ready}, 32'd0);
    step();

    // 2: LDUR then ADDI back-to-back
    start_pulse();
    chk("t2_done_cleared", {31'b0, done}, 32'd0);
    send(OP_LDUR, 5'd5, 5'd2, 5'd0, 19'd8, 1'b0, 1'b1, 2'd0, 32'hF8408045);
    send(OP_ADDI, 5'd1, 5'd31, 5'd0, 19'd5, 1'b0, 1'b1, 2'd1, 32'h910017E1);
    step();
    if (wr_cyc.size() >= 2) chk("t2_b2b_gap", wr_cyc[$] - wr_cyc[$-1], 32'd1);
    else chk("t2_write_count", wr_cyc.size(), 32'd2);

    // 3: CBZ / CBNZ; last on the final slot lands in DONE, not FULL
    send(OP_CBZ, 5'd4, 5'd0, 5'd0, 19'd3, 1'b0, 1'b1, 2'd2, 32'hB4000064);
    send(OP_CBNZ, 5'd4, 5'd0, 5'd0, 19'd3, 1'b1, 1'b1, 2'd3, 32'hB5000064);
    chk("t3_done", {31'b0, done}, 32'd1);
    chk("t3_overflow", {31'b0, overflow}, 32'd0);
    step();

    // 4: fill imem without last, fifth descriptor overflows
    start_pulse();
    send(OP_SUB, 5'd7, 5'd8, 5'd9, 19'd0, 1'b0, 1'b1, 2'd0, model(1, 7, 8, 9, 0));
    send(OP_AND, 5'd10, 5'd11, 5'd12, 19'd0, 1'b0, 1'b1, 2'd1, model(2, 10, 11, 12, 0));
    send(OP_ORR, 5'd31, 5'd0, 5'd17, 19'd0, 1'b0, 1'b1, 2'd2, model(3, 31, 0, 17, 0));
    send(OP_STUR, 5'd6, 5'd29, 5'd0, 19'h7FFFC, 1'b0, 1'b1, 2'd3, model(6, 6, 29, 0, -4));
    chk("t4_full_in_ready", {31'b0, in_ready}, 32'd0);
    chk("t4_overflow_before", {31'b0, overflow}, 32'd0);
    send(OP_ADD, 5'd1, 5'd1, 5'd1, 19'd0, 1'b0, 1'b0, 2'd0, 32'd0);
    chk("t4_overflow", {31'b0, overflow}, 32'd1);
    chk("t4_done", {31'b0, done}, 32'd0);
    chk("t4_err", {31'b0, err}, 32'd0);
    step();

    // start while loading: descriptor offered with start is dropped
    start_pulse();
    chk("restart_overflow_cleared", {31'b0, overflow}, 32'd0);
    send(OP_SUB, 5'd2, 5'd3, 5'd4, 19'd0, 1'b0, 1'b1, 2'd0, model(1, 2, 3, 4, 0));
    in_op = OP_AND; in_rd = 5'd9; in_valid = 1'b1; start = 1'b1;
    step();
    in_valid = 1'b0; start = 1'b0;
    chk("restart_in_ready", {31'b0, in_ready}, 32'd1);
    send(OP_ORR, 5'd5, 5'd6, 5'd7, 19'd0, 1'b1, 1'b1, 2'd0, model(3, 5, 6, 7, 0));
    step();

    // 5: reset mid-stream drops the pending write
    start_pulse();
    send(OP_ADD, 5'd1, 5'd2, 5'd3, 19'd0, 1'b0, 1'b1, 2'd0, model(0, 1, 2, 3, 0));
    in_op = OP_SUB; in_rd = 5'd4; in_rn = 5'd5; in_rm = 5'd6; in_valid = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    #1;
    chk("t5_wr_en", {31'b0, wr_en}, 32'd0);
    chk("t5_in_ready", {31'b0, in_ready}, 32'd0);
    chk("t5_wr_addr", {30'b0, wr_addr}, 32'd0);
    chk("t5_wr_data", wr_data, 32'd0);
    step();
    step();
    reset = 1'b0;
    step();
    start_pulse();
    send(OP_ADD, 5'd3, 5'd1, 5'd2, 19'd0, 1'b1, 1'b1, 2'd0, 32'h8B020023);
    step();

    // 6: ADDI imm=5000 out of range
`ifdef ARKI_ENC_RANGE_CHECK_EN
    exp_w = 32'h0;
    exp_e = 1'b1;
`else
    exp_w = (32'h244 << 22) | (32'd904 << 10) | (32'd2 << 5) | 32'd3;
    exp_e = 1'b0;
`endif
    start_pulse();
    send(OP_ADDI, 5'd3, 5'd2, 5'd0, 19'd5000, 1'b1, 1'b1, 2'd0, exp_w);
    chk("t6_err", {31'b0, err}, {31'b0, exp_e});
    step();

    // unknown opcode always writes zero
    start_pulse();
    chk("t7_err_cleared", {31'b0, err}, 32'd0);
    send(4'd9, 5'd1, 5'd1, 5'd1, 19'd1, 1'b1, 1'b1, 2'd0, 32'h0);
    chk("t7_err", {31'b0, err}, {31'b0, exp_e});
    step();
    step();

    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
